rca_slice_sequencer: RTL

- Multi-cycle 64-bit add/subtract unit built from one SLICE-bit ripple-carry slice.
- The slice is reused over WIDTH/SLICE cycles, with the carry held in a register between cycles.
- Trades latency for area against the full-width combinational ripple adders.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.

---
 rtl/rca_slice_sequencer_if.sv | 37 +++
 rtl/rca_slice_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rca_slice_sequencer_if.sv
// Operand/result handshake bundle for rca_slice_sequencer; master = producer/consumer side, slave = adder.
// ovf and its modport entries exist only when RCA_SEQ_OVF_EN is defined.
interface rca_slice_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_valid;
  logic             out_ready;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, sum, c_out, out_valid, ovf
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, sum, c_out, out_valid, ovf
  );
`else
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, sum, c_out, out_valid
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, sum, c_out, out_valid
  );
`endif
endinterface

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle add/sub reusing one SLICE-bit ripple slice; result valid WIDTH/SLICE edges after accept.
// Result held in DONE until out_ready; operands refused while busy or flushing. Optional ovf: RCA_SEQ_OVF_EN.
module rca_slice_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  rca_slice_sequencer_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
  logic               msb_cin;
`endif

  logic [IDX_W-1:0]   slice_base;
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic [SLICE:0]     slice_res;
  logic               in_ready_w;

  assign in_ready_w    = (state_q == IDLE) && !flush;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign busy          = (state_q != IDLE);
`ifdef RCA_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

  // The single shared ripple slice, steered by the slice counter.
  always_comb begin
    slice_base = IDX_W'(cnt_q) * IDX_W'(SLICE);
    a_sl       = a_q[slice_base +: SLICE];
    b_sl       = b_q[slice_base +: SLICE];
    slice_res  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
  end

`ifdef RCA_SEQ_OVF_EN
  // Carry into the top bit, recovered from the top bit's sum and operand bits.
  assign msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_res[SLICE-1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          c_out_d = 1'b0;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          sum_d[slice_base +: SLICE] = slice_res[SLICE-1:0];
          carry_d                    = slice_res[SLICE];
          if (cnt_q == CNT_W'(NSLICE - 1)) begin
            state_d = DONE;
            c_out_d = slice_res[SLICE];
`ifdef RCA_SEQ_OVF_EN
            ovf_d   = msb_cin ^ slice_res[SLICE];
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
          c_out_d = 1'b0;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule
